// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared types and constants for the instruction-memory image loader.
//   state_t        : loader FSM states
//   IMEM_DEPTH     : instruction memory depth in words
//   BYTES_PER_WORD : bytes packed into one instruction word
//   count_ok()     : true when an image word count can be loaded
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    localparam int IMEM_DEPTH     = 64;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        WRITE,
        CHECK,
        DONE,
        ERR
    } state_t;

    // A header byte is a legal word count when it is 1..IMEM_DEPTH.
    function automatic logic count_ok(input logic [7:0] n);
        return (n != 8'd0) && (n <= 8'(IMEM_DEPTH));
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// -----------------------------------------------------------------------------
// imem_word_packer
// Packs a byte stream into little-endian 32-bit words. Bytes enter at the top
// of a right-shifting register, so after four shifts the first byte sits in
// bits [7:0].
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_shift_en     : a byte is accepted this cycle
//   i_byte         : the accepted byte
//   i_clear        : restart at byte 0 of a new word
//   o_word_next    : word value after shifting i_byte in (complete word when
//                    o_word_ready is high)
//   o_word_ready   : the byte being accepted this cycle completes a word
// -----------------------------------------------------------------------------
module imem_word_packer
    import imem_loader_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_shift_en,
    input  logic [7:0]        i_byte,
    input  logic              i_clear,
    output logic [DATA_W-1:0] o_word_next,
    output logic              o_word_ready
);

    logic [DATA_W-1:0] r_word;
    logic [1:0]        r_byte_idx;

    // Offered combinationally so the FSM can register the finished word on the
    // same edge that accepts its last byte.
    assign o_word_next  = {i_byte, r_word[DATA_W-1:8]};
    assign o_word_ready = i_shift_en && (r_byte_idx == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_word     <= '0;
            r_byte_idx <= '0;
        end else if (i_clear) begin
            r_byte_idx <= '0;
        end else if (i_shift_en) begin
            r_word     <= o_word_next;
            r_byte_idx <= r_byte_idx + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Receives a program image as a byte stream and writes it into the 64x32
// instruction memory while holding the CPU. Image: count byte N (1..64),
// 4*N little-endian data bytes, one XOR checksum byte over everything before.
// Ports:
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_rx_valid    : byte available on i_rx_data
//   i_rx_data     : incoming byte
//   o_rx_ready    : loader accepts a byte this cycle
//   o_mem_we      : one-cycle write strobe
//   o_mem_addr    : write word address
//   o_mem_wdata   : write data
//   o_cpu_hold    : CPU held while high
//   o_load_done   : one-cycle pulse after a good image
//   o_load_err    : sticky error, cleared by the next image's first byte
//   o_state       : current FSM state (debug visibility)
//
// Handshake: a byte transfers on a rising edge where i_rx_valid && o_rx_ready.
// The sender holds i_rx_data stable while i_rx_valid is high and not accepted;
// o_rx_ready depends only on state, never on i_rx_valid.
// -----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    output logic              o_rx_ready,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_cpu_hold,
    output logic              o_load_done,
    output logic              o_load_err,
    output state_t            o_state
);

    state_t            r_state;
    logic [ADDR_W:0]   r_word_cnt;
    logic [ADDR_W:0]   r_n;
    logic [7:0]        r_csum;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_cpu_hold;
    logic              r_load_done;
    logic              r_load_err;

    logic              w_xfer;
    logic              w_shift;
    logic              w_pack_clear;
    logic [DATA_W-1:0] w_word_next;
    logic              w_word_ready;
    logic [ADDR_W:0]   w_cnt_inc;

    // DONE and ERR also refuse bytes so the first byte of the next image is
    // never swallowed by a one-cycle exit state.
    assign o_rx_ready   = (r_state == IDLE) || (r_state == DATA) || (r_state == CHECK);
    assign w_xfer       = i_rx_valid && o_rx_ready;
    assign w_shift      = w_xfer && (r_state == DATA);
    assign w_pack_clear = (r_state == WRITE) || (r_state == IDLE);
    assign w_cnt_inc    = r_word_cnt + 1'b1;

    imem_word_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_shift_en   (w_shift),
        .i_byte       (i_rx_data),
        .i_clear      (w_pack_clear),
        .o_word_next  (w_word_next),
        .o_word_ready (w_word_ready)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_word_cnt  <= '0;
            r_n         <= '0;
            r_csum      <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_hold  <= 1'b0;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_mem_we    <= 1'b0;
            r_load_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_csum     <= i_rx_data;
                        r_cpu_hold <= 1'b1;
                        r_word_cnt <= '0;
                        r_n        <= i_rx_data[ADDR_W:0];
                        if (count_ok(i_rx_data)) begin
                            r_load_err <= 1'b0;
                            r_state    <= DATA;
                        end else begin
                            r_load_err <= 1'b1;
                            r_state    <= ERR;
                        end
                    end
                end
                DATA: begin
                    if (w_xfer) begin
                        r_csum <= r_csum ^ i_rx_data;
                        if (w_word_ready) begin
                            // Strobe is registered here so it is high exactly
                            // during the WRITE cycle.
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= r_word_cnt[ADDR_W-1:0];
                            r_mem_wdata <= w_word_next;
                            r_state     <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    r_word_cnt <= w_cnt_inc;
                    r_state    <= (w_cnt_inc == r_n) ? CHECK : DATA;
                end
                CHECK: begin
                    if (w_xfer) begin
                        if (i_rx_data == r_csum) begin
                            r_load_done <= 1'b1;
                            r_cpu_hold  <= 1'b0;
                            r_state     <= DONE;
                        end else begin
                            r_load_err <= 1'b1;
                            r_state    <= ERR;
                        end
                    end
                end
                DONE:    r_state <= IDLE;
                ERR:     r_state <= IDLE;  // hold stays high: bad image must not run
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_cpu_hold  = r_cpu_hold;
    assign o_load_done = r_load_done;
    assign o_load_err  = r_load_err;
    assign o_state     = r_state;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data  = 8'h00;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;
  state_t            dbg_state;

  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rx_valid  (rx_valid),
    .i_rx_data   (rx_data),
    .o_rx_ready  (rx_ready),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_cpu_hold  (cpu_hold),
    .o_load_done (load_done),
    .o_load_err  (load_err),
    .o_state     (dbg_state)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int done_cnt     = 0;

  // scoreboard: expected writes as {addr, data}
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  typedef struct {
    logic [7:0]       n;
    int               nw;
    logic [1:0][31:0] words;
    logic [7:0]       csum;
    bit               thr;
    bit               exp_done;
    bit               exp_err;
  } vec_t;

  vec_t vecs [0:7];

  function automatic vec_t mk(input logic [7:0] n, input int nw, input logic [31:0] w0,
                              input logic [31:0] w1, input logic [7:0] cs, input bit thr,
                              input bit dn, input bit er);
    vec_t v;
    v.n = n; v.nw = nw; v.words[0] = w0; v.words[1] = w1; v.csum = cs;
    v.thr = thr; v.exp_done = dn; v.exp_err = er;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // write monitor / scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (load_done) done_cnt++;
      if (mem_we) begin
        check("we_blocks_ready", 64'(rx_ready), 64'd0);
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_write: got addr %0h data %08h expected no write", mem_addr, mem_wdata);
        end else begin
          logic [ADDR_W+DATA_W-1:0] e;
          e = exp_q.pop_front();
          if ({mem_addr, mem_wdata} !== e) begin
            tests_failed++;
            $display("FAIL write: got addr %0h data %08h expected addr %0h data %08h",
                     mem_addr, mem_wdata, e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
          end
        end
      end
    end
  end

  // driver: inputs change 1 time unit after the rising edge
  task automatic send_byte(input logic [7:0] b, input bit thr);
    bit acc;
    int guard;
    if (thr) begin
      guard = 0;
      while ($urandom_range(0, 1) == 1 && guard < 8) begin
        rx_valid = 1'b0;
        @(posedge clk); #1;
        guard++;
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) begin
      acc = rx_ready;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    if (!acc) begin
      tests_run++;
      tests_failed++;
      $display("FAIL rx_timeout: got no accept for byte %02h expected accept within 20 cycles", b);
    end
  endtask

  task automatic run_image(input vec_t v, input string tag);
    logic [31:0] w;
    done_cnt = 0;
    for (int i = 0; i < v.nw; i++) exp_q.push_back({ADDR_W'(i), v.words[i]});
    send_byte(v.n, v.thr);
    check({tag, "_hold_after_hdr"}, 64'(cpu_hold), 64'd1);
    check({tag, "_err_after_hdr"}, 64'(load_err), (v.nw == 0) ? 64'd1 : 64'd0);
    for (int i = 0; i < v.nw; i++) begin
      w = v.words[i];
      for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], v.thr);
      check({tag, "_we_latency"}, 64'(mem_we), 64'd1);
      check({tag, "_we_addr"}, 64'(mem_addr), 64'(i));
    end
    if (v.nw > 0) begin
      send_byte(v.csum, v.thr);
      if (v.exp_done) check({tag, "_done_latency"}, 64'(load_done), 64'd1);
      else            check({tag, "_err_latency"}, 64'(load_err), 64'd1);
    end
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_count"}, 64'(done_cnt), v.exp_done ? 64'd1 : 64'd0);
    check({tag, "_load_err"}, 64'(load_err), 64'(v.exp_err));
    check({tag, "_cpu_hold"}, 64'(cpu_hold), 64'(v.exp_err));
    check({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    // 02 ^ (F0^0F^FF^00) ^ (3A^12^FC^12) = 02 ^ 00 ^ C6 = C4
    vecs[0] = mk(8'h02, 2, 32'h00FF0FF0, 32'h12FC123A, 8'hC4, 1'b0, 1'b1, 1'b0);
    vecs[1] = mk(8'h02, 2, 32'h00FF0FF0, 32'h12FC123A, 8'hC5, 1'b0, 1'b0, 1'b1);
    vecs[2] = mk(8'h02, 2, 32'h00FF0FF0, 32'h12FC123A, 8'hC4, 1'b0, 1'b1, 1'b0);
    vecs[3] = mk(8'h00, 0, 32'h0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b1);
    vecs[4] = mk(8'h41, 0, 32'h0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b1);
    vecs[5] = mk(8'hFF, 0, 32'h0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b1);
    // 01 ^ EF ^ BE ^ AD ^ DE = 23
    vecs[6] = mk(8'h01, 1, 32'hDEADBEEF, 32'h0, 8'h23, 1'b0, 1'b1, 1'b0);
    vecs[7] = mk(8'h02, 2, 32'h00FF0FF0, 32'h12FC123A, 8'hC4, 1'b1, 1'b1, 1'b0);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_rx_ready", 64'(rx_ready), 64'd1);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_cpu_hold", 64'(cpu_hold), 64'd0);
    check("rst_load_done", 64'(load_done), 64'd0);
    check("rst_load_err", 64'(load_err), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));

    for (int i = 0; i < 8; i++) run_image(vecs[i], $sformatf("vec%0d", i));

    // full depth: word k = BBBB00kk; BB^BB cancels and XOR of 0..63 is 0, so csum = 40
    done_cnt = 0;
    for (int k = 0; k < 64; k++) exp_q.push_back({ADDR_W'(k), 16'hBBBB, 8'h00, 8'(k)});
    send_byte(8'h40, 1'b0);
    for (int k = 0; k < 64; k++) begin
      w = {16'hBBBB, 8'h00, 8'(k)};
      for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], 1'b0);
    end
    check("full_last_addr", 64'(mem_addr), 64'd63);
    send_byte(8'h40, 1'b0);
    check("full_done_latency", 64'(load_done), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("full_done_count", 64'(done_cnt), 64'd1);
    check("full_load_err", 64'(load_err), 64'd0);
    check("full_cpu_hold", 64'(cpu_hold), 64'd0);
    check("full_writes_left", 64'(exp_q.size()), 64'd0);

    // bad image leaves err set, then reset mid-load of the nominal image
    run_image(vecs[1], "pre_rst");
    exp_q.push_back({ADDR_W'(0), 32'h00FF0FF0});
    send_byte(8'h02, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h0F, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h3A, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_state", 64'(dbg_state), 64'(IDLE));
    check("midrst_cpu_hold", 64'(cpu_hold), 64'd0);
    check("midrst_load_err", 64'(load_err), 64'd0);
    check("midrst_rx_ready", 64'(rx_ready), 64'd1);
    check("midrst_writes_left", 64'(exp_q.size()), 64'd0);
    rst = 1'b0;
    run_image(vecs[0], "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
